// File: rtl/sync_debounce_bank_pkg.sv
// Shared constants and elaboration-time helpers for the synchroniser/debounce bank.
package sync_debounce_bank_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;
    localparam int unsigned MIN_NUM_CH      = 1;
    localparam int unsigned MAX_NUM_CH      = 32;
    localparam int unsigned MIN_DEBOUNCE    = 1;
    localparam int unsigned MAX_DEBOUNCE    = 65535;

    // Ceiling log2; callers pass values >= 2 so the result is at least 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // True when every parameter is inside its legal range.
    function automatic bit params_ok(input int unsigned num_ch,
                                     input int unsigned sync_stages,
                                     input int unsigned debounce_cycles);
        return (num_ch >= MIN_NUM_CH) && (num_ch <= MAX_NUM_CH) &&
               (sync_stages >= MIN_SYNC_STAGES) && (sync_stages <= MAX_SYNC_STAGES) &&
               (debounce_cycles >= MIN_DEBOUNCE) && (debounce_cycles <= MAX_DEBOUNCE);
    endfunction

endpackage

// File: rtl/sync_debounce_bank_channel.sv
// Single-bit debounce filter: stability counter, filtered level and edge strobes.
module debounce_channel
    import sync_debounce_bank_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_BIT       = 1'b0
) (
    input  logic aclk,
    input  logic areset,
    input  logic sync_in,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic update_c
);

    localparam int unsigned     CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Level takes the synchronised value on the last consecutive disagreeing edge.
    assign update_c = (sync_in != dout) && (cnt == CNT_LAST);

    // Counter, level and strobe registers; any agreement restarts the count.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt  <= '0;
            dout <= RESET_BIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_in == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt  <= '0;
                dout <= sync_in;
                rise <= sync_in;
                fall <= ~sync_in;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sync_debounce_bank.sv
// Multi-channel pin synchroniser with per-channel debounce and edge strobes.
module sync_debounce_bank
    import sync_debounce_bank_pkg::*;
#(
    parameter int unsigned       NUM_CH          = 8,
    parameter int unsigned       SYNC_STAGES     = 2,
    parameter int unsigned       DEBOUNCE_CYCLES = 16,
    parameter logic [NUM_CH-1:0] RESET_LEVEL     = '0
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] sync_out,
    output logic [NUM_CH-1:0] dout,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              changed
);

    // Reject out-of-range parameters at elaboration.
    if (!params_ok(NUM_CH, SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_param_check
        $error("sync_debounce_bank: parameter out of range");
    end

    (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] update_c;

    // Synchroniser shift chain, loaded with the reset level on reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RESET_LEVEL;
            end
        end else begin
            sync_q[0] <= din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_LEVEL[g])
        ) u_ch (
            .aclk     (aclk),
            .areset   (areset),
            .sync_in  (sync_q[SYNC_STAGES-1][g]),
            .dout     (dout[g]),
            .rise     (rise[g]),
            .fall     (fall[g]),
            .update_c (update_c[g])
        );
    end

    // Registered any-channel-changed flag, aligned with the rise/fall strobes.
    always_ff @(posedge aclk) begin
        if (areset) begin
            changed <= 1'b0;
        end else begin
            changed <= |update_c;
        end
    end

endmodule
